// File: rtl/artemis_ddr3_pkg.sv
// Shared definitions for the artemis DDR3 user-port master: MCB command codes,
// FSM state encoding and sticky error-flag bit positions.
package artemis_ddr3_pkg;

   localparam logic [2:0] CMD_WR      = 3'b000;
   localparam logic [2:0] CMD_RD      = 3'b001;
   localparam logic [2:0] CMD_WR_AP   = 3'b010;
   localparam logic [2:0] CMD_RD_AP   = 3'b011;
   localparam logic [2:0] CMD_REFRESH = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_FILL  = 3'd1,
      ST_WR_CMD   = 3'd2,
      ST_RD_CMD   = 3'd3,
      ST_RD_DRAIN = 3'd4,
      ST_DONE     = 3'd5
   } state_e;

   localparam int ERR_W           = 5;
   localparam int ERR_WR_UNDERRUN = 0;
   localparam int ERR_WR_ERROR    = 1;
   localparam int ERR_RD_OVERFLOW = 2;
   localparam int ERR_RD_ERROR    = 3;
   localparam int ERR_TIMEOUT     = 4;

   // The port takes word-aligned byte addresses only.
   function automatic logic [29:0] align_addr(input logic [29:0] a);
      return {a[29:2], 2'b00};
   endfunction

endpackage

// File: rtl/artemis_ddr3_watchdog.sv
// Idle-cycle watchdog: counts consecutive enabled cycles without a transfer and
// flags expiry on the TIMEOUT_CYCLES-th such cycle.
module artemis_ddr3_watchdog #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TO_WIDTH       = 13
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic expire_o
);

   localparam logic [TO_WIDTH-1:0] LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [TO_WIDTH-1:0] cnt_q, cnt_d;

   assign expire_o = en_i && !clr_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!en_i || clr_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/artemis_ddr3_port_master.sv
// Master for one artemis DDR3 user port: writes fill the write FIFO before the
// command is pushed, reads push the command and then drain the read FIFO.
module artemis_ddr3_port_master
   import artemis_ddr3_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TO_WIDTH       = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        calibration_done,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [29:0] req_addr,
   input  logic [5:0]  req_bl,
   input  logic [31:0] wdata,
   input  logic        wdata_valid,
   output logic        wdata_ready,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   input  logic        rdata_ready,
   output logic        done,
   output logic [4:0]  err_flags,
   output logic        busy,
   output logic        cmd_en,
   output logic [2:0]  cmd_instr,
   output logic [5:0]  cmd_bl,
   output logic [29:0] cmd_byte_addr,
   input  logic        cmd_full,
   output logic        wr_en,
   output logic [3:0]  wr_mask,
   output logic [31:0] wr_data,
   input  logic        wr_full,
   input  logic        wr_underrun,
   input  logic        wr_error,
   output logic        rd_en,
   input  logic [31:0] rd_data,
   input  logic        rd_empty,
   input  logic        rd_overflow,
   input  logic        rd_error
);

   state_e            state_q, state_d;
   logic              rd_q, rd_d;
   logic [5:0]        bl_q, bl_d;
   logic [29:0]       addr_q, addr_d;
   logic [5:0]        wcnt_q, wcnt_d;
   logic [ERR_W-1:0]  err_q, err_d;

   logic accept;
   logic xfer;
   logic last_xfer;
   logic wd_en;
   logic wd_expire;

   // req_ready is gated by rst_n so every handshake output is low while reset is held.
   assign req_ready   = rst_n && calibration_done && (state_q == ST_IDLE);
   assign accept      = req_valid && req_ready;

   assign wdata_ready = (state_q == ST_WR_FILL) && !wr_full;
   assign wr_en       = wdata_valid && wdata_ready;
   assign wr_data     = wdata;
   assign wr_mask     = 4'b0000;

   assign rdata       = rd_data;
   assign rdata_valid = (state_q == ST_RD_DRAIN) && !rd_empty;
   assign rd_en       = rdata_valid && rdata_ready;

   assign cmd_en        = ((state_q == ST_WR_CMD) || (state_q == ST_RD_CMD)) && !cmd_full;
   assign cmd_instr     = rd_q ? CMD_RD : CMD_WR;
   assign cmd_bl        = bl_q;
   assign cmd_byte_addr = addr_q;

   assign done      = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign err_flags = err_q;

   assign xfer      = wr_en || rd_en;
   assign last_xfer = xfer && (wcnt_q == bl_q);
   assign wd_en     = (state_q == ST_WR_FILL) || (state_q == ST_RD_DRAIN);

   artemis_ddr3_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_WIDTH       (TO_WIDTH)
   ) u_watchdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (wd_en),
      .clr_i    (xfer),
      .expire_o (wd_expire)
   );

   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      bl_d    = bl_q;
      addr_d  = addr_q;
      wcnt_d  = wcnt_q;
      err_d   = err_q;

      if (xfer) begin
         wcnt_d = wcnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = req_write ? ST_WR_FILL : ST_RD_CMD;
               rd_d    = !req_write;
               bl_d    = req_bl;
               addr_d  = align_addr(req_addr);
               wcnt_d  = '0;
               err_d   = '0;
            end
         end
         // A timed-out write skips WR_CMD so no command is pushed for partial data.
         ST_WR_FILL: begin
            if (wd_expire) begin
               state_d = ST_DONE;
            end else if (last_xfer) begin
               state_d = ST_WR_CMD;
            end
         end
         ST_WR_CMD: begin
            if (!cmd_full) begin
               state_d = ST_DONE;
            end
         end
         ST_RD_CMD: begin
            if (!cmd_full) begin
               state_d = ST_RD_DRAIN;
            end
         end
         ST_RD_DRAIN: begin
            if (wd_expire || last_xfer) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Controller error inputs are sticky and only reported, never acted upon.
      if (wd_expire)   err_d[ERR_TIMEOUT]     = 1'b1;
      if (wr_underrun) err_d[ERR_WR_UNDERRUN] = 1'b1;
      if (wr_error)    err_d[ERR_WR_ERROR]    = 1'b1;
      if (rd_overflow) err_d[ERR_RD_OVERFLOW] = 1'b1;
      if (rd_error)    err_d[ERR_RD_ERROR]    = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rd_q    <= 1'b0;
         bl_q    <= '0;
         addr_q  <= '0;
         wcnt_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         bl_q    <= bl_d;
         addr_q  <= addr_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: doc/artemis_ddr3_port_master.md
Name: artemis_ddr3_port_master

Overview:
- Master for one user port (cmd/wr/rd FIFO triplet) of the artemis DDR3 controller wrapper.
- Converts a host request (address, burst length, direction) plus a valid/ready data stream into correctly ordered port operations:
  - Write: fill the write FIFO first, then issue the command.
  - Read: issue the command, then drain the read FIFO.
- Watchdog on read drain; error conditions are latched.
- Single clock domain: the port's cmd/wr/rd clocks are all tied to clk at integration.

Parameters:
- TIMEOUT_CYCLES, 4096, max cycles in RD_DRAIN/WR_FILL without a data transfer before abort; minimum 2.
- TO_WIDTH, 13, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; also drives the port's cmd/wr/rd clocks.
- rst_n  in  1  asynchronous active-low reset.
- calibration_done  in  1  controller calibration complete.
- req_valid  in  1  host request valid.
- req_ready  out  1  request accepted when req_valid&req_ready.
- req_write  in  1  1=write, 0=read.
- req_addr  in  30  byte address; bits[1:0] ignored (forced 0).
- req_bl  in  6  burst length minus one (1..64 words).
- wdata  in  32  write word.
- wdata_valid  in  1  write word valid.
- wdata_ready  out  1  write word accepted.
- rdata  out  32  read word.
- rdata_valid  out  1  read word valid.
- rdata_ready  in  1  host accepts read word.
- done  out  1  one-cycle pulse at end of request.
- err_flags  out  5  sticky {timeout, rd_error, rd_overflow, wr_error, wr_underrun}.
- busy  out  1  state != IDLE.
- cmd_en  out  1  port command push.
- cmd_instr  out  3  000 write, 001 read.
- cmd_bl  out  6  registered req_bl.
- cmd_byte_addr  out  30  registered {req_addr[29:2],2'b00}.
- cmd_full  in  1  command FIFO full.
- wr_en  out  1  write FIFO push.
- wr_mask  out  4  constant 4'b0000.
- wr_data  out  32  equals wdata.
- wr_full  in  1  write FIFO full.
- wr_underrun  in  1  controller write underrun.
- wr_error  in  1  controller write error.
- rd_en  out  1  read FIFO pop.
- rd_data  in  32  read FIFO head.
- rd_empty  in  1  read FIFO empty.
- rd_overflow  in  1  controller read overflow.
- rd_error  in  1  controller read error.

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0, except: cmd_instr=000, wr_mask=0, wr_data/rdata follow their inputs.
  - Counters cleared; err_flags cleared.
- States: IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DRAIN, DONE.
- IDLE:
  - req_ready = calibration_done.
  - On accept: latch addr/bl/dir; word counter = 0; watchdog = 0; err_flags cleared.
  - Next state: WR_FILL for a write, RD_CMD for a read.
- WR_FILL:
  - wdata_ready = !wr_full; wr_en = wdata_valid & wdata_ready (combinational pass-through).
  - Count each push. After word bl+1 is pushed, go to WR_CMD next cycle.
- WR_CMD:
  - cmd_en=1 with cmd_instr=000 in any cycle where !cmd_full; then DONE.
  - If cmd_full, hold cmd_en low and wait.
- RD_CMD:
  - cmd_en=1, cmd_instr=001 when !cmd_full; then RD_DRAIN.
- RD_DRAIN:
  - rdata = rd_data; rdata_valid = !rd_empty; rd_en = rdata_valid & rdata_ready.
  - Count pops. After word bl+1 is popped, go to DONE.
- DONE:
  - done=1 for exactly one cycle; next state IDLE.
- Latency:
  - Write with continuous data and no full: cmd_en asserts in cycle bl+2 after accept (accept = cycle 0).
  - Read: cmd_en asserts the cycle after accept.
- Only one cmd_en per request; a command is never issued before its write data is fully pushed.
- Watchdog:
  - Active in WR_FILL and RD_DRAIN only.
  - Increments on cycles with no transfer; resets on each transfer.
  - Reaching TIMEOUT_CYCLES sets err_flags[4] and moves to DONE (done still pulses).
  - On a write timeout, no command is issued.
- Controller error inputs: any cycle high sets the corresponding err_flags bit. This is informational only; the state machine is unaffected.
- Calibration: calibration_done falling mid-request does not abort the request; it only blocks new accepts.
- Reset mid-operation: immediate return to IDLE, all outputs cleared. FIFO contents are the integrator's concern.

Decomposition:
- Shared package artemis_ddr3_pkg:
  - MCB instruction constants: CMD_WR=3'b000, CMD_RD=3'b001, CMD_WR_AP=3'b010, CMD_RD_AP=3'b011, CMD_REFRESH=3'b100.
  - State encoding typedef.
  - Error-bit index constants.
- One natural sub-module: artemis_ddr3_watchdog (counter, clear, enable, expire).

Test Plan:
- Write addr=0x100, bl=3, wdata 0xA0..0xA3 continuous → 4 wr_en cycles, then one cmd_en with instr=000, bl=3, addr=0x100; done 1 cycle later.
- Read addr=0x103, bl=1; rd_empty low for 2 words 0x11,0x22 → cmd_byte_addr=0x100, instr=001; rdata 0x11 then 0x22; done pulse.
- Write with wr_full high for cycles 2-5 and cmd_full high 3 cycles → wdata_ready low while full; no word lost; cmd_en held until !cmd_full; exactly one cmd_en.
- Read with rd_empty stuck high, TIMEOUT_CYCLES=16 → err_flags=5'b10000 after 16 cycles; done pulses; back in IDLE, req_ready=1.
- calibration_done=0 with req_valid=1 → req_ready=0, no cmd_en. Then pulse rd_overflow during a read → err_flags[2] set, read still completes, flag cleared on next accept.
- rst_n asserted mid WR_FILL → all outputs 0 asynchronously; after release, busy=0 and a new request completes normally.
